weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- PicoRV32 memory-mapped peripheral; the write side of the weight memories that the accelerator controller reads.
- Firmware streams layer-1 and layer-2 weights word by word into two weight RAM write ports.
- On seal, the block pads the rest of each region with the 32'h7fffffff end-of-layer sentinel, so the controller's read counters halt at the right place.
- Raises load_done once both layers are sealed; this releases the accelerator to start.

Parameters:
- BASE_ADDR, 32'h0300_0000, byte base of the 16-byte register window.
- DEPTH1, 1024, layer-1 weight RAM depth in words.
- DEPTH2, 64, layer-2 weight RAM depth in words.
- AW, 10, RAM address width; must satisfy 2**AW >= DEPTH1 and DEPTH2.
- SENTINEL, 32'h7fffffff, end-of-layer marker word.
- MIN_PAD, 2, minimum sentinel words per region; the controller halts on two consecutive sentinels.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  PicoRV32 native bus request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read, 4'hF = write; other values are ignored (ready still given)
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid when mem_ready=1
- we1 / waddr1 / wdata1  out  1/AW/32  layer-1 RAM write port
- we2 / waddr2 / wdata2  out  1/AW/32  layer-2 RAM write port
- load_done  out  1  done1 & done2
- busy  out  1  high while in LOAD or PAD

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ptr=0; sel=0; done1=done2=0; err=0; ovf=0.
  - All outputs 0.
- Register map (mem_addr[3:2], hit when mem_addr[31:4]==BASE_ADDR[31:4]):
  - 0 CTRL (W): bit0 BEGIN, bit1 LAYER (0=L1, 1=L2), bit2 SEAL, bit3 CLR_ERR.
  - 1 DATA (W): pushes one weight word.
  - 2 STATUS (R): {27'b0, busy, ovf, err, done2, done1}.
  - 3 COUNT (R): zero-extended ptr.
  - Reads of CTRL and DATA return 0. No response on a miss.
- Bus handshake:
  - On a hit with mem_valid=1 and mem_ready=0, the access is performed and mem_ready=1 on the next cycle, for exactly one cycle.
  - mem_ready is never asserted two consecutive cycles.
  - mem_rdata is 0 whenever mem_ready=0.
- FSM states: IDLE, LOAD, PAD.
  - IDLE: BEGIN moves to LOAD; sel=LAYER, ptr=0, done[sel] cleared.
  - LOAD, DATA write:
    - If wdata==SENTINEL: err=1, word dropped.
    - Else if ptr==DEPTHsel-MIN_PAD: ovf=1, word dropped.
    - Else: we_sel=1, waddr=ptr, wdata=word on the acknowledge cycle; ptr+1.
  - LOAD, SEAL: move to PAD.
  - LOAD, BEGIN: restart; ptr=0, sel=LAYER. The previous partial region is abandoned and done stays 0.
  - PAD: one sentinel write per cycle at ptr, ptr+1, until ptr==DEPTHsel-1 has been written. Then done[sel]=1 and state returns to IDLE.
    - Pad length = DEPTHsel - count, always >= MIN_PAD.
  - Any CTRL/DATA write while in PAD is acknowledged, ignored, and sets err. STATUS/COUNT reads are served normally.
- Simultaneous flags:
  - BEGIN together with SEAL in one CTRL write: BEGIN wins.
  - CLR_ERR clears err and ovf in any state, and takes effect alongside other bits.
  - DATA or SEAL in IDLE: err=1.
- Write ports: we1 and we2 are never high together. The inactive port holds addr/data at 0.
- load_done is combinational from the done flags and drops immediately when BEGIN clears a done flag.
- resetn deasserted mid-PAD aborts the pad; done for that layer stays 0, so firmware must reload.

Decomposition:
- Shared package weight_loader_pkg:
  - register offsets;
  - CTRL bit positions;
  - STATUS bit positions;
  - state encoding;
  - SENTINEL, the single definition shared with the controller.
- One natural sub-module, wl_bus_if:
  - address decode;
  - one-cycle mem_ready generation;
  - read mux.
- FSM, ptr and write-port drive remain in the top level.

Test Plan:
- BEGIN L1, push 785 words (value = index+1), SEAL:
  - we1 for addr 0..784 with matching data;
  - then 239 cycles of SENTINEL at 785..1023;
  - done1=1; COUNT reads 1024.
- BEGIN L2, push 33 words, SEAL:
  - SENTINEL at 33..63;
  - done2=1; load_done=1 on the cycle done2 sets.
- L2, push 63 words:
  - words 0..61 written;
  - 63rd word dropped, ovf=1;
  - SEAL pads addr 62..63 (exactly 2 sentinels).
- Push 32'h7fffffff as data in LOAD:
  - no we pulse, err=1;
  - CTRL CLR_ERR brings STATUS back to busy only (0x10).
- During PAD, read STATUS:
  - acked with busy=1 while sentinel writes continue;
  - write DATA during PAD gives err=1 and no extra we.
- Drop resetn for 1 cycle mid-PAD:
  - all outputs 0 immediately;
  - done flags 0; next BEGIN starts at ptr 0.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader and the accelerator controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package weight_loader_pkg;

    // Register word offsets, taken from mem_addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_BEGIN   = 0;
    localparam int CTRL_LAYER   = 1;
    localparam int CTRL_SEAL    = 2;
    localparam int CTRL_CLR_ERR = 3;

    // STATUS bit positions
    localparam int ST_DONE1 = 0;
    localparam int ST_DONE2 = 1;
    localparam int ST_ERR   = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_BUSY  = 4;

    localparam logic [3:0] WSTRB_READ  = 4'h0;
    localparam logic [3:0] WSTRB_WRITE = 4'hF;

    // End-of-layer marker; the controller's read counters stop on two in a row
    localparam logic [31:0] WL_SENTINEL = 32'h7fff_ffff;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2
    } wl_state_t;

    function automatic logic [31:0] pack_status(input logic busy, input logic ovf,
                                                input logic err, input logic done2,
                                                input logic done1);
        logic [31:0] s;
        s           = '0;
        s[ST_BUSY]  = busy;
        s[ST_OVF]   = ovf;
        s[ST_ERR]   = err;
        s[ST_DONE2] = done2;
        s[ST_DONE1] = done1;
        return s;
    endfunction

endpackage

// File: rtl/wl_bus_if.sv
// PicoRV32 native-bus slave front end: address decode, ack generation, read mux.
// Latency: access performed on the request edge, mem_ready one cycle later for one cycle.
// Backpressure: none; every hit is acknowledged, misses are never acknowledged.
// Ports: mem_* CPU bus; i_status/i_count read sources; o_wr_vld/o_reg write strobe to the core.
module wl_bus_if
    import weight_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] i_status,
    input  logic [31:0] i_count,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        o_wr_vld,
    output logic [1:0]  o_reg
);

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        w_hit;
    logic        w_acc;
    logic        w_rd;
    logic [31:0] w_rval;
    logic        w_unused_addr;

    assign w_unused_addr = ^mem_addr[1:0];

    assign w_hit = (mem_addr[31:4] == BASE_ADDR[31:4]);
    // While mem_ready is high the CPU still shows the finished request; blocking
    // here keeps a held request from being performed twice.
    assign w_acc = mem_valid && w_hit && !r_ready;
    assign w_rd  = w_acc && (mem_wstrb == WSTRB_READ);

    assign o_reg    = mem_addr[3:2];
    assign o_wr_vld = w_acc && (mem_wstrb == WSTRB_WRITE);

    always_comb begin
        w_rval = '0;
        case (o_reg)
            REG_STATUS: w_rval = i_status;
            REG_COUNT:  w_rval = i_count;
            default:    w_rval = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_rd ? w_rval : 32'h0;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_ready ? r_rdata : 32'h0;

endmodule

// File: rtl/weight_loader.sv
// Firmware-driven writer for the layer-1/layer-2 weight RAMs with sentinel padding on seal.
// Latency: RAM write issued on the bus ack cycle; pad writes one sentinel per cycle.
// Backpressure: none; writes arriving during PAD are acked and dropped (err set).
// Ports: mem_* PicoRV32 bus; we/waddr/wdata 1 and 2 RAM write ports; load_done, busy status.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH1    = 1024,
    parameter int          DEPTH2    = 64,
    parameter int          AW        = 10,
    parameter logic [31:0] SENTINEL  = WL_SENTINEL,
    parameter int          MIN_PAD   = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          we1,
    output logic [AW-1:0] waddr1,
    output logic [31:0]   wdata1,
    output logic          we2,
    output logic [AW-1:0] waddr2,
    output logic [31:0]   wdata2,
    output logic          load_done,
    output logic          busy
);

    // One extra bit so the pointer can show the full depth once padding ends
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LIM1 = PW'(DEPTH1 - MIN_PAD);
    localparam logic [PW-1:0] LIM2 = PW'(DEPTH2 - MIN_PAD);
    localparam logic [PW-1:0] END1 = PW'(DEPTH1 - 1);
    localparam logic [PW-1:0] END2 = PW'(DEPTH2 - 1);

    wl_state_t     r_state;
    logic [PW-1:0] r_ptr;
    logic          r_sel;
    logic          r_done1;
    logic          r_done2;
    logic          r_err;
    logic          r_ovf;
    logic          r_we1;
    logic          r_we2;
    logic [AW-1:0] r_waddr1;
    logic [AW-1:0] r_waddr2;
    logic [31:0]   r_wdata1;
    logic [31:0]   r_wdata2;

    logic          w_wr_vld;
    logic [1:0]    w_reg;
    logic          w_ctrl_wr;
    logic          w_data_wr;
    logic          w_begin;
    logic          w_seal;
    logic          w_clr;
    logic          w_layer;
    logic [PW-1:0] w_lim;
    logic [PW-1:0] w_end;
    logic [31:0]   w_status;
    logic [31:0]   w_count;

    assign busy      = (r_state != S_IDLE);
    assign load_done = r_done1 & r_done2;
    assign w_status  = pack_status(busy, r_ovf, r_err, r_done2, r_done1);
    assign w_count   = 32'(r_ptr);

    wl_bus_if #(
        .BASE_ADDR (BASE_ADDR)
    ) u_bus_if (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .i_status  (w_status),
        .i_count   (w_count),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .o_wr_vld  (w_wr_vld),
        .o_reg     (w_reg)
    );

    assign w_ctrl_wr = w_wr_vld && (w_reg == REG_CTRL);
    assign w_data_wr = w_wr_vld && (w_reg == REG_DATA);
    assign w_begin   = w_ctrl_wr && mem_wdata[CTRL_BEGIN];
    assign w_seal    = w_ctrl_wr && mem_wdata[CTRL_SEAL];
    assign w_clr     = w_ctrl_wr && mem_wdata[CTRL_CLR_ERR];
    assign w_layer   = mem_wdata[CTRL_LAYER];
    assign w_lim     = r_sel ? LIM2 : LIM1;
    assign w_end     = r_sel ? END2 : END1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_sel    <= 1'b0;
            r_done1  <= 1'b0;
            r_done2  <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_we1    <= 1'b0;
            r_we2    <= 1'b0;
            r_waddr1 <= '0;
            r_waddr2 <= '0;
            r_wdata1 <= '0;
            r_wdata2 <= '0;
        end else begin
            // Write ports idle at zero unless a write is issued below
            r_we1    <= 1'b0;
            r_we2    <= 1'b0;
            r_waddr1 <= '0;
            r_waddr2 <= '0;
            r_wdata1 <= '0;
            r_wdata2 <= '0;

            // Clear first so any error raised by the same write still lands
            if (w_clr) begin
                r_err <= 1'b0;
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_begin) begin
                        // BEGIN outranks SEAL and abandons any partial region
                        r_state <= S_LOAD;
                        r_sel   <= w_layer;
                        r_ptr   <= '0;
                        if (w_layer) r_done2 <= 1'b0;
                        else         r_done1 <= 1'b0;
                    end else if (w_seal) begin
                        if (r_state == S_LOAD) r_state <= S_PAD;
                        else                   r_err   <= 1'b1;
                    end

                    if (w_data_wr) begin
                        if (r_state == S_IDLE || mem_wdata == SENTINEL) begin
                            r_err <= 1'b1;
                        end else if (r_ptr == w_lim) begin
                            // Keep MIN_PAD slots free for the end-of-layer markers
                            r_ovf <= 1'b1;
                        end else begin
                            if (r_sel) begin
                                r_we2    <= 1'b1;
                                r_waddr2 <= r_ptr[AW-1:0];
                                r_wdata2 <= mem_wdata;
                            end else begin
                                r_we1    <= 1'b1;
                                r_waddr1 <= r_ptr[AW-1:0];
                                r_wdata1 <= mem_wdata;
                            end
                            r_ptr <= r_ptr + PW'(1);
                        end
                    end
                end

                S_PAD: begin
                    if (w_ctrl_wr || w_data_wr) r_err <= 1'b1;
                    if (r_sel) begin
                        r_we2    <= 1'b1;
                        r_waddr2 <= r_ptr[AW-1:0];
                        r_wdata2 <= SENTINEL;
                    end else begin
                        r_we1    <= 1'b1;
                        r_waddr1 <= r_ptr[AW-1:0];
                        r_wdata1 <= SENTINEL;
                    end
                    r_ptr <= r_ptr + PW'(1);
                    if (r_ptr == w_end) begin
                        r_state <= S_IDLE;
                        if (r_sel) r_done2 <= 1'b1;
                        else       r_done1 <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign we1    = r_we1;
    assign waddr1 = r_waddr1;
    assign wdata1 = r_wdata1;
    assign we2    = r_we2;
    assign waddr2 = r_waddr2;
    assign wdata2 = r_wdata2;

endmodule

// File: tb/tb_weight_loader.sv
// Randomised self-checking bench for weight_loader against a region-level firmware model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int D1 = 1024;
    localparam int D2 = 64;
    localparam logic [31:0] SENT = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        we1, we2, load_done, busy;
    logic [9:0]  waddr1, waddr2;
    logic [31:0] wdata1, wdata2;

    weight_loader dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .load_done(load_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Firmware-level model: flags plus the list of words that should land in the region
    bit m_busy, m_pad, m_sel, m_done1, m_done2, m_err, m_ovf;
    logic [31:0] kept[$];

    // Captured RAM contents and port statistics
    logic [31:0] act1 [D1];
    logic [31:0] act2 [D2];
    int w1_cnt, w2_cnt, s1_cnt, s2_cnt, last_waddr1;
    int both_hi, idle_bad, dbl_ready, rdata_bad;
    bit prev_ready;
    bit ld_at_done;

    always @(negedge clk) begin
        if (we1 && we2) both_hi++;
        if (!we1 && (waddr1 != 0 || wdata1 != 0)) idle_bad++;
        if (!we2 && (waddr2 != 0 || wdata2 != 0)) idle_bad++;
        if (we1) begin
            act1[waddr1] = wdata1; w1_cnt++; last_waddr1 = int'(waddr1);
            if (wdata1 == SENT) s1_cnt++;
        end
        if (we2) begin
            act2[waddr2] = wdata2; w2_cnt++;
            if (wdata2 == SENT) s2_cnt++;
        end
        if (mem_ready && prev_ready) dbl_ready++;
        if (!mem_ready && mem_rdata != 0) rdata_bad++;
        prev_ready = mem_ready;
    end

    function automatic logic [31:0] model_status();
        return {27'b0, m_busy, m_ovf, m_err, m_done2, m_done1};
    endfunction

    function automatic int region_mismatches(input bit layer);
        int n = 0;
        int depth = layer ? D2 : D1;
        for (int i = 0; i < depth; i++) begin
            logic [31:0] e = (i < kept.size()) ? kept[i] : SENT;
            logic [31:0] a = layer ? act2[i] : act1[i];
            if (a !== e) n++;
        end
        return n;
    endfunction

    task automatic clear_capture();
        for (int i = 0; i < D1; i++) act1[i] = 32'hdead_beef;
        for (int i = 0; i < D2; i++) act2[i] = 32'hdead_beef;
        w1_cnt = 0; w2_cnt = 0; s1_cnt = 0; s2_cnt = 0; last_waddr1 = -1;
    endtask

    task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rv, output bit ok);
        ok = 0; rv = '0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin ok = 1; rv = mem_rdata; break; end
        end
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        #1;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] rv; bit ok;
        bus_access(BASE + 32'(r) * 4, d, 4'hF, rv, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ack_wr reg=%0d: no mem_ready, required ack within 8 cycles", r); end
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        bit ok;
        bus_access(BASE + 32'(r) * 4, 32'h0, 4'h0, v, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ack_rd reg=%0d: no mem_ready, required ack within 8 cycles", r); end
    endtask

    // Firmware operations, each applying the register-map rules to the model
    task automatic fw_begin(input bit layer, input bit with_seal);
        wr(REG_CTRL, {29'b0, with_seal, layer, 1'b1});
        if (m_pad) m_err = 1;
        else begin
            m_busy = 1; m_sel = layer; kept.delete();
            if (layer) m_done2 = 0; else m_done1 = 0;
        end
    endtask

    task automatic fw_seal();
        wr(REG_CTRL, 32'h4);
        if (!m_busy || m_pad) m_err = 1; else m_pad = 1;
    endtask

    task automatic fw_clr();
        wr(REG_CTRL, 32'h8);
        m_ovf = 0;
        m_err = m_pad;
    endtask

    task automatic fw_push(input logic [31:0] d);
        wr(REG_DATA, d);
        if (!m_busy || m_pad || d == SENT) m_err = 1;
        else if (kept.size() == ((m_sel ? D2 : D1) - 2)) m_ovf = 1;
        else kept.push_back(d);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] d = $urandom;
        return (d == SENT) ? 32'h1 : d;
    endfunction

    task automatic wait_pad_done();
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; ld_at_done = load_done; break; end
        end
        #1;
        checks++;
        if (!seen) begin errors++; $display("FAIL pad_timeout: busy still 1, required 0 within 3000 cycles"); end
        else begin
            m_busy = 0; m_pad = 0;
            if (m_sel) m_done2 = 1; else m_done1 = 1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v; bit ok;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (|{we1, we2, waddr1, waddr2, wdata1, wdata2, mem_ready, mem_rdata, load_done, busy} !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero, required all 0");
        end
        resetn = 1'b1;
        rd(REG_STATUS, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 0", v); end
        rd(REG_COUNT, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h, required 0", v); end
        rd(REG_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h, required 0", v); end
        bus_access(BASE + 32'h10, 32'h0, 4'h0, v, ok);
        checks++; if (ok) begin errors++; $display("FAIL miss_ack: got ack on miss, required none"); end
    endtask

    task automatic test_l1_load();
        logic [31:0] v;
        clear_capture();
        fw_begin(1'b0, 1'b0);
        for (int i = 0; i < 785; i++) fw_push(32'(i + 1));
        fw_seal();
        wait_pad_done();
        checks++; if (region_mismatches(1'b0) != 0) begin errors++; $display("FAIL l1_region: %0d words wrong, required 0", region_mismatches(1'b0)); end
        checks++; if (w1_cnt != 1024 || w2_cnt != 0) begin errors++; $display("FAIL l1_writes: we1=%0d we2=%0d, required 1024/0", w1_cnt, w2_cnt); end
        checks++; if (s1_cnt != 239) begin errors++; $display("FAIL l1_pad_len: got %0d, required 239", s1_cnt); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL l1_status: got %h, required %h", v, model_status()); end
        rd(REG_COUNT, v);
        checks++; if (v !== 32'd1024) begin errors++; $display("FAIL l1_count: got %0d, required 1024", v); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL l1_load_done: got %b, required 0", load_done); end
    endtask

    task automatic test_l2_load();
        logic [31:0] v;
        clear_capture();
        fw_begin(1'b1, 1'b0);
        for (int i = 0; i < 33; i++) fw_push(rand_word());
        fw_seal();
        wait_pad_done();
        checks++; if (ld_at_done !== (m_done1 & m_done2)) begin errors++; $display("FAIL l2_load_done_edge: got %b, required %b", ld_at_done, m_done1 & m_done2); end
        checks++; if (region_mismatches(1'b1) != 0) begin errors++; $display("FAIL l2_region: %0d words wrong, required 0", region_mismatches(1'b1)); end
        checks++; if (s2_cnt != 31 || w2_cnt != 64) begin errors++; $display("FAIL l2_writes: sent=%0d total=%0d, required 31/64", s2_cnt, w2_cnt); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL l2_status: got %h, required %h", v, model_status()); end
    endtask

    task automatic test_begin_restart_overflow();
        logic [31:0] v;
        fw_begin(1'b0, 1'b0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL begin_drops_done: got %b, required 0", load_done); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL begin_status: got %h, required %h", v, model_status()); end
        clear_capture();
        fw_begin(1'b1, 1'b0);
        for (int i = 0; i < 63; i++) fw_push(rand_word());
        checks++; if (w2_cnt != 62 || w1_cnt != 0) begin errors++; $display("FAIL ovf_writes: we2=%0d we1=%0d, required 62/0", w2_cnt, w1_cnt); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL ovf_status: got %h, required %h", v, model_status()); end
        rd(REG_COUNT, v);
        checks++; if (v !== 32'd62) begin errors++; $display("FAIL ovf_count: got %0d, required 62", v); end
        fw_seal();
        wait_pad_done();
        checks++; if (s2_cnt != 2) begin errors++; $display("FAIL ovf_pad_len: got %0d, required 2", s2_cnt); end
        checks++; if (region_mismatches(1'b1) != 0) begin errors++; $display("FAIL ovf_region: %0d words wrong, required 0", region_mismatches(1'b1)); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL ovf_done_status: got %h, required %h", v, model_status()); end
    endtask

    task automatic test_errors();
        logic [31:0] v; bit ok;
        fw_clr();
        fw_push(rand_word());
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL idle_data_err: got %h, required %h", v, model_status()); end
        fw_clr();
        clear_capture();
        fw_begin(1'b1, 1'b0);
        fw_push(SENT);
        checks++; if (w2_cnt != 0 || w1_cnt != 0) begin errors++; $display("FAIL sentinel_drop: we count %0d, required 0", w2_cnt + w1_cnt); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL sentinel_err: got %h, required %h", v, model_status()); end
        fw_clr();
        rd(REG_STATUS, v);
        checks++; if (v !== 32'h10) begin errors++; $display("FAIL clr_err: got %h, required 10", v); end
        bus_access(BASE + 32'h4, 32'h1234, 4'h3, v, ok);
        checks++; if (!ok || w2_cnt != 0) begin errors++; $display("FAIL partial_strobe: ack=%b we2=%0d, required 1/0", ok, w2_cnt); end
        fw_begin(1'b1, 1'b1);
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL begin_wins: got %h, required %h", v, model_status()); end
        for (int i = 0; i < 3; i++) fw_push(rand_word());
        fw_seal();
        wait_pad_done();
        checks++; if (region_mismatches(1'b1) != 0 || w2_cnt != 64) begin errors++; $display("FAIL short_l2: mism=%0d writes=%0d, required 0/64", region_mismatches(1'b1), w2_cnt); end
    endtask

    task automatic test_pad_access();
        logic [31:0] v;
        int a;
        clear_capture();
        fw_begin(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) fw_push(rand_word());
        fw_seal();
        a = s1_cnt;
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL pad_status: got %h, required %h", v, model_status()); end
        checks++; if (s1_cnt <= a) begin errors++; $display("FAIL pad_progress: sentinels %0d, required more than %0d", s1_cnt, a); end
        fw_push(rand_word());
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL pad_data_err: got %h, required %h", v, model_status()); end
        wait_pad_done();
        checks++; if (w1_cnt != 1024 || region_mismatches(1'b0) != 0) begin errors++; $display("FAIL pad_no_extra: writes=%0d mism=%0d, required 1024/0", w1_cnt, region_mismatches(1'b0)); end
        rd(REG_STATUS, v);
        checks++; if (v !== model_status()) begin errors++; $display("FAIL pad_final_status: got %h, required %h", v, model_status()); end
    endtask

    task automatic test_reset_mid_pad();
        logic [31:0] v;
        logic [31:0] d;
        fw_clr();
        fw_begin(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) fw_push(rand_word());
        fw_seal();
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (|{we1, we2, waddr1, waddr2, wdata1, wdata2, mem_ready, mem_rdata, load_done, busy} !== 1'b0) begin
            errors++; $display("FAIL midpad_reset_outputs: some output nonzero, required all 0");
        end
        m_busy = 0; m_pad = 0; m_sel = 0; m_done1 = 0; m_done2 = 0; m_err = 0; m_ovf = 0;
        @(negedge clk);
        resetn = 1'b1;
        rd(REG_STATUS, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midpad_status: got %h, required 0", v); end
        clear_capture();
        fw_begin(1'b0, 1'b0);
        d = rand_word();
        fw_push(d);
        checks++; if (w1_cnt != 1 || last_waddr1 != 0 || act1[0] !== d) begin
            errors++; $display("FAIL restart_addr: writes=%0d addr=%0d data=%h, required 1/0/%h", w1_cnt, last_waddr1, act1[0], d);
        end
        rd(REG_COUNT, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL restart_count: got %0d, required 1", v); end
    endtask

    task automatic test_invariants();
        checks++; if (both_hi != 0) begin errors++; $display("FAIL both_we: got %0d cycles, required 0", both_hi); end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_port: got %0d cycles nonzero, required 0", idle_bad); end
        checks++; if (dbl_ready != 0) begin errors++; $display("FAIL ready_twice: got %0d, required 0", dbl_ready); end
        checks++; if (rdata_bad != 0) begin errors++; $display("FAIL rdata_idle: got %0d, required 0", rdata_bad); end
    endtask

    initial begin
        clear_capture();
        test_reset();
        test_l1_load();
        test_l2_load();
        test_begin_restart_overflow();
        test_errors();
        test_pad_access();
        test_reset_mid_pad();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
